// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transfer arbiter: FSM states and attempt result.
package i2c_arb_pkg;

  localparam int XFER_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_END,
    GAP
  } state_t;

  typedef enum logic {
    RES_OK,
    RES_FAIL
  } res_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping mod N_REQ.
module i2c_rr_pick #(
  parameter  int N_REQ = 3,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  logic [PW-1:0] idx;

  // Scan offsets from far to near so the request nearest to ptr overwrites last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_xfer_arbiter.sv
// Shares one I2C_Controller between N_REQ register-write requesters.
// Round-robin grant, GO/END/ACK handshake with retry on NACK or timeout,
// and a one-cycle done/err pulse back to the winning requester.
module i2c_xfer_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int XFER_W      = i2c_arb_pkg::XFER_W,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int GO_LOW_CYC  = 5000
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*XFER_W-1:0] req_data,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic                    busy,
  output logic [XFER_W-1:0]       i2c_data,
  output logic                    i2c_go,
  input  logic                    i2c_end,
  input  logic                    i2c_ack
);

  localparam int PW      = $clog2(N_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYC > GO_LOW_CYC) ? TIMEOUT_CYC : GO_LOW_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t        state, nxt;
  res_t          res;
  logic [PW-1:0] ptr, winner, pickIdx, nextPtr;
  logic          pickVld;
  logic [RW-1:0] retryCnt;
  logic [CW-1:0] cnt;
  logic          endMeta, endS, ackMeta, ackS;
  logic          tmo, gapDone, attemptEnd, attemptOk;

  i2c_rr_pick #(.N_REQ(N_REQ)) uPick (
    .req    (req),
    .ptr    (ptr),
    .winner (pickIdx),
    .valid  (pickVld)
  );

  // One counter serves as attempt timer and GO-low gap timer; it saturates.
  assign tmo     = (cnt >= CW'(TIMEOUT_CYC - 1));
  assign gapDone = (cnt >= CW'(GO_LOW_CYC - 1));
  assign nextPtr = (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
  assign busy    = (state != IDLE);

  // END/ACK come from the controller's divided clock: two-flop synchronisers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      endMeta <= 1'b0;
      endS    <= 1'b0;
      ackMeta <= 1'b0;
      ackS    <= 1'b0;
    end else begin
      endMeta <= i2c_end;
      endS    <= endMeta;
      ackMeta <= i2c_ack;
      ackS    <= ackMeta;
    end
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nxt;
  end

  // Next state; a completed END takes precedence over a coincident timeout.
  always_comb begin
    nxt        = state;
    attemptEnd = 1'b0;
    attemptOk  = 1'b0;
    unique case (state)
      IDLE:       if (pickVld) nxt = ISSUE;
      ISSUE:      nxt = WAIT_START;
      WAIT_START: begin
        if (tmo) begin
          attemptEnd = 1'b1;
          nxt        = GAP;
        end else if (!endS) begin
          nxt = WAIT_END;
        end
      end
      WAIT_END: begin
        if (endS) begin
          attemptEnd = 1'b1;
          attemptOk  = !ackS;
          nxt        = GAP;
        end else if (tmo) begin
          attemptEnd = 1'b1;
          nxt        = GAP;
        end
      end
      GAP: begin
        if (gapDone) begin
          if (res == RES_OK)                    nxt = IDLE;
          else if (retryCnt < RW'(MAX_RETRY))   nxt = ISSUE;
          else                                  nxt = IDLE;
        end
      end
      default:    nxt = IDLE;
    endcase
  end

  // Datapath: grant latch, GO, timers, retry count, pointer and result pulses.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      done     <= '0;
      err      <= '0;
      i2c_go   <= 1'b0;
      i2c_data <= '0;
      winner   <= '0;
      ptr      <= '0;
      retryCnt <= '0;
      cnt      <= '0;
      res      <= RES_OK;
    end else begin
      done <= '0;
      err  <= '0;
      unique case (state)
        IDLE: begin
          if (pickVld) begin
            winner   <= pickIdx;
            i2c_data <= req_data[int'(pickIdx)*XFER_W +: XFER_W];
            retryCnt <= '0;
          end
        end
        ISSUE: begin
          i2c_go <= 1'b1;
          cnt    <= '0;
        end
        WAIT_START, WAIT_END: begin
          if (attemptEnd) begin
            i2c_go <= 1'b0;
            cnt    <= '0;
            res    <= attemptOk ? RES_OK : RES_FAIL;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gapDone) begin
            if (res == RES_OK) begin
              done[winner] <= 1'b1;
              ptr          <= nextPtr;
            end else if (retryCnt < RW'(MAX_RETRY)) begin
              retryCnt <= retryCnt + 1'b1;
            end else begin
              err[winner] <= 1'b1;
              ptr         <= nextPtr;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// Bench for i2c_xfer_arbiter: behavioural controller model plus a
// scoreboard of expected completions (requester, done/err, data, GO count).
module tb_i2c_xfer_arbiter;

  localparam int N    = 3;
  localparam int W    = 24;
  localparam int TMO  = 100;
  localparam int GAPC = 8;

  logic             iCLK = 1'b0;
  logic             iRST_N = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     done, err;
  logic             busy;
  logic [W-1:0]     i2c_data;
  logic             i2c_go;
  logic             i2c_end, i2c_ack;

  always #5 iCLK = ~iCLK;

  i2c_xfer_arbiter #(
    .N_REQ(N), .XFER_W(W), .MAX_RETRY(3), .TIMEOUT_CYC(TMO), .GO_LOW_CYC(GAPC)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .req(req), .req_data(req_data),
    .done(done), .err(err), .busy(busy), .i2c_data(i2c_data), .i2c_go(i2c_go),
    .i2c_end(i2c_end), .i2c_ack(i2c_ack)
  );

  typedef struct {
    int          idx;
    bit          isErr;
    logic [W-1:0] data;
    int          gos;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           nChk = 0, nErr = 0;
  int           goCnt = 0, goBase = 0, goHigh = 0, lastGoHigh = 0;
  logic [W-1:0] lastData = '0;
  int           nackLeft = 0;
  bit           stuck = 1'b0, startReq = 1'b0, goSeen = 1'b0;
  bit [N-1:0]   keep = '0;
  int           obsIdx;

  task automatic chk(input string tag, input longint got, input longint exp);
    nChk++;
    if (got != exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Controller model, GO side: count GO pulses, record data and high time.
  initial forever begin
    @(negedge iCLK);
    if (i2c_go) begin
      goHigh++;
      if (!goSeen) begin
        goSeen   = 1'b1;
        goCnt++;
        lastData = i2c_data;
        if (!stuck) startReq = 1'b1;
      end
    end else begin
      if (goHigh > 0) lastGoHigh = goHigh;
      goHigh = 0;
      goSeen = 1'b0;
    end
  end

  // Controller model, bus side: END low while busy, then END high with ACK.
  initial begin
    i2c_end = 1'b1;
    i2c_ack = 1'b1;
    forever begin
      @(negedge iCLK);
      if (startReq) begin
        startReq = 1'b0;
        repeat (3) @(negedge iCLK);
        i2c_end = 1'b0;
        repeat (12) @(negedge iCLK);
        if (nackLeft > 0) begin
          i2c_ack = 1'b1;
          nackLeft--;
        end else begin
          i2c_ack = 1'b0;
        end
        i2c_end = 1'b1;
      end
    end
  end

  // Completion monitor: pop and compare, then release the requester.
  initial forever begin
    @(negedge iCLK);
    if ((done | err) != '0) begin
      chk("pulse_onehot", $countones({done, err}), 1);
      obsIdx = 0;
      for (int i = 0; i < N; i++) if (done[i] | err[i]) obsIdx = i;
      if (q.size() == 0) begin
        chk("sb_pending", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("idx", obsIdx, e.idx);
        chk("is_err", |err, e.isErr);
        chk("data", lastData, e.data);
        chk("go_pulses", goCnt - goBase, e.gos);
      end
      goBase = goCnt;
      if (keep[obsIdx]) keep[obsIdx] = 1'b0;
      else              req[obsIdx]  = 1'b0;
    end
  end

  task automatic raise(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
    req[i] = 1'b1;
  endtask

  task automatic expectXfer(input int i, input bit isErr, input logic [W-1:0] d, input int g);
    exp_t x;
    x.idx = i; x.isErr = isErr; x.data = d; x.gos = g;
    q.push_back(x);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    chk("drain_left", q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge iCLK);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_go", i2c_go, 0);
    chk("rst_data", i2c_data, 0);
    iRST_N = 1'b1;
    @(negedge iCLK);

    // Simultaneous requests: order 0,1,2 twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        expectXfer(i, 1'b0, W'(24'hA00000 + r*16 + i), 1);
        raise(i, W'(24'hA00000 + r*16 + i));
      end
      waitDrain(600);
    end

    // Two NACKs then ACK.
    nackLeft = 2;
    expectXfer(1, 1'b0, 24'h123456, 3);
    raise(1, 24'h123456);
    waitDrain(1000);

    // Always NACK: first attempt plus three retries.
    nackLeft = 1000;
    expectXfer(2, 1'b1, 24'h654321, 4);
    raise(2, 24'h654321);
    waitDrain(1000);
    nackLeft = 0;

    // Controller never starts: each attempt times out.
    stuck = 1'b1;
    expectXfer(0, 1'b1, 24'hBEEF01, 4);
    raise(0, 24'hBEEF01);
    waitDrain(2000);
    chk("tmo_len", lastGoHigh, TMO);
    stuck = 1'b0;

    // Reset during WAIT_END: GO drops at once, no pulse.
    raise(2, 24'h0BAD00);
    n = 0;
    while (i2c_end && n < 200) begin
      @(negedge iCLK);
      n++;
    end
    chk("end_seen", i2c_end, 0);
    repeat (4) @(negedge iCLK);
    #2 iRST_N = 1'b0;
    #1;
    chk("arst_go", i2c_go, 0);
    chk("arst_busy", busy, 0);
    req = '0;
    repeat (30) @(negedge iCLK);
    iRST_N = 1'b1;
    goBase = goCnt;
    @(negedge iCLK);

    // Single request with latency check.
    expectXfer(0, 1'b0, 24'h729803, 1);
    raise(0, 24'h729803);
    @(negedge iCLK);
    chk("lat1_go", i2c_go, 0);
    @(negedge iCLK);
    chk("lat2_go", i2c_go, 1);
    chk("go_data", i2c_data, 24'h729803);
    waitDrain(600);

    // req dropped mid-transfer still completes.
    expectXfer(1, 1'b0, 24'h5A5A5A, 1);
    raise(1, 24'h5A5A5A);
    n = 0;
    while (!i2c_go && n < 50) begin
      @(negedge iCLK);
      n++;
    end
    chk("drop_go", i2c_go, 1);
    repeat (5) @(negedge iCLK);
    req[1] = 1'b0;
    waitDrain(600);

    // req held after done is a second transaction.
    keep[1] = 1'b1;
    expectXfer(1, 1'b0, 24'hC3C3C3, 1);
    expectXfer(1, 1'b0, 24'hC3C3C3, 1);
    raise(1, 24'hC3C3C3);
    waitDrain(600);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule

// File: doc/i2c_xfer_arbiter.md
Name: i2c_xfer_arbiter

Overview:
- Shares the single I2C_Controller instance between N independent register-write requesters, e.g. HDMI transmitter config, audio codec config and runtime debug writes.
- Each requester presents one 24-bit transaction {slave_addr, sub_addr, data}. The block picks a requester round-robin, drives GO, tracks END/ACK, retries on NACK or timeout, and returns a per-requester done or error pulse.
- Runs on the system clock. The controller runs on its slower divided clock, so END and ACK are synchronised inside this block.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- XFER_W, 24, transaction width.
- MAX_RETRY, 3, attempts after the first before declaring error.
- TIMEOUT_CYC, 2000000, iCLK cycles allowed from GO assertion to END completion.
- GO_LOW_CYC, 5000, iCLK cycles GO is held low between transactions; must cover at least 2 controller clock periods.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- req_data  in  N_REQ*XFER_W  transaction data; requester i occupies bits [i*24 +: 24].
- done  out  N_REQ  one-cycle pulse: transaction ACKed.
- err  out  N_REQ  one-cycle pulse: retries exhausted.
- busy  out  1  high whenever not in IDLE.
- i2c_data  out  XFER_W  to controller I2C_DATA.
- i2c_go  out  1  to controller GO.
- i2c_end  in  1  from controller END (controller clock domain).
- i2c_ack  in  1  from controller ACK; 0 means acknowledged.

Behaviour:
- Reset values: done=0, err=0, busy=0, i2c_go=0, i2c_data=0. Round-robin pointer=0, retry count=0, state=IDLE, synchroniser flops=0.
- Synchronisation: i2c_end and i2c_ack each pass through a 2-flop synchroniser. Only the synchronised versions (end_s, ack_s) are used.
- Handshake: a requester raises req with req_data stable and holds both until its done or err pulse. Once granted, req_data is latched; a req drop mid-transfer is ignored and the transaction completes with its pulse. Any req still high after a pulse is a new transaction.
- Arbitration: the highest-priority asserted req wins. Priority starts at pointer and wraps modulo N_REQ. After any completion, done or err, pointer = winner+1 mod N_REQ.
- IDLE: if any req is set, latch the winner index and its data into i2c_data, clear retry count, go to ISSUE. Decision is made in the same cycle req is sampled.
- ISSUE: assert i2c_go, clear the timer, go to WAIT_START.
- WAIT_START: wait for end_s=0 (controller has started) -> WAIT_END.
- WAIT_END: wait for end_s=1, then sample ack_s.
  - ack_s=0: success.
  - ack_s=1: failure.
  - Either way drop i2c_go and go to GAP.
- Timer: counts in WAIT_START and WAIT_END. Reaching TIMEOUT_CYC is a failure: drop i2c_go, go to GAP.
- GAP: hold i2c_go=0 for GO_LOW_CYC cycles, then:
  - on success, pulse done[winner] and go to IDLE;
  - on failure with retry count < MAX_RETRY, increment the count and go to ISSUE, reusing the latched data;
  - on failure otherwise, pulse err[winner] and go to IDLE.
- done and err are never both high, and at most one bit of each is high.
- Latency: req to i2c_go rising = 2 cycles (IDLE, ISSUE). END to done = 2 sync cycles + 1 + GO_LOW_CYC.
- Simultaneous requests: only one transaction is in flight. Others wait without being dropped. No requester waits longer than N_REQ-1 other transactions.
- Asynchronous reset mid-transfer: i2c_go drops immediately and all state clears. The controller's own reset, same iRST_N, aborts the bus. No done or err pulse is generated for the aborted transaction.
- Timer and GAP counter are sized by $clog2 of the larger of TIMEOUT_CYC and GO_LOW_CYC. Counters saturate and never wrap.

Decomposition:
- Package i2c_arb_pkg holds:
  - XFER_W;
  - the state enum {IDLE, ISSUE, WAIT_START, WAIT_END, GAP};
  - a result enum {RES_OK, RES_FAIL}.
- Sub-module i2c_rr_pick: round-robin priority pick with inputs req and pointer, outputs winner index and valid. Combinational, instantiated once.

Test Plan:
- Single request: req[0] with 24'h72_9803, controller model ACKs -> i2c_data=24'h729803, i2c_go high until END, done[0] pulses once, busy falls after GO_LOW_CYC.
- Three simultaneous requests, all ACK -> service order 0,1,2. Raise all again -> order 0,1,2 again, since pointer=0 after winner 2.
- Model NACKs twice then ACKs, MAX_RETRY=3 -> exactly 3 GO pulses and done pulses. Model always NACKs -> 4 GO pulses, err pulses, done never pulses.
- Model never starts, END stuck at 1; TIMEOUT_CYC reduced to 100 for the test -> each attempt aborts at 100 cycles, err after 4 attempts.
- iRST_N asserted during WAIT_END -> i2c_go=0 the same instant, no done or err, and the next request is serviced normally after reset release.
- req[1] dropped mid-transfer -> transfer completes and done[1] pulses. With req[1] held after done -> second transaction starts.
